// File: rtl/mc_control_unit.sv
// mc_control_unit: multi-cycle MIPS control FSM.
// Sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK over a shared memory and ALU,
// stalling on mem_ready and holding EXECUTE for MUL_CYCLES on mul (opcode 28).
// Optional build macro MC_CTRL_COP0_EN adds the COP_EX state (opcode 16) and
// the cop_rs / coprocessor ports.
module mc_control_unit #(
  parameter int ALUOP_W    = 5,
  parameter int MUL_CYCLES = 3,
  parameter int CNT_W      = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               mem_ready,
`ifdef MC_CTRL_COP0_EN
  input  logic [4:0]         cop_rs,
  output logic               coprocessor,
`endif
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         pc_source,
  output logic               link,
  output logic               arith_u,
  output logic [3:0]         byte_control,
  output logic [ALUOP_W-1:0] alu_opcode,
  output logic               busy,
  output logic               illegal_op
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_RTYPE_EX,
    S_IMM_EX, S_MUL_EX, S_ALU_WB, S_BRANCH, S_JUMP, S_COP_EX
  } state_t;

  state_t           state, next_state;
  logic [CNT_W-1:0] mul_cnt;
  logic             mul_done;
  logic             is_load, is_store, is_rtype, is_imm, is_mul;
  logic             is_branch, is_jump, is_cop, illegal_dec;
  logic [3:0]       width_bc;

  assign mul_done = (mul_cnt == CNT_W'(MUL_CYCLES - 1));

  // Opcode classification and access width; IR is stable from DECODE until the next FETCH.
  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_imm    = 1'b0;
    is_branch = 1'b0;
    is_jump   = 1'b0;
    is_cop    = 1'b0;
    width_bc  = 4'b0000;
    case (opcode)
      6'd35: begin is_load  = 1'b1; width_bc = 4'b1111; end
      6'd33, 6'd37: begin is_load = 1'b1; width_bc = 4'b0011; end
      6'd32, 6'd36: begin is_load = 1'b1; width_bc = 4'b0001; end
      6'd43: begin is_store = 1'b1; width_bc = 4'b1111; end
      6'd41: begin is_store = 1'b1; width_bc = 4'b0011; end
      6'd40: begin is_store = 1'b1; width_bc = 4'b0001; end
      6'd8, 6'd9, 6'd10, 6'd11, 6'd12, 6'd13, 6'd14, 6'd15: is_imm = 1'b1;
      6'd4, 6'd5, 6'd6, 6'd7, 6'd1: is_branch = 1'b1;
      6'd2, 6'd3: is_jump = 1'b1;
`ifdef MC_CTRL_COP0_EN
      6'd16: is_cop = 1'b1;
`endif
      default: ;
    endcase
    is_rtype    = (opcode == 6'd0);
    is_mul      = (opcode == 6'd28);
    illegal_dec = !(is_load | is_store | is_rtype | is_imm | is_mul |
                    is_branch | is_jump | is_cop);
  end

  // State, mul hold counter and the two registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_FETCH;
      mul_cnt    <= '0;
      busy       <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      state      <= next_state;
      busy       <= (next_state != S_FETCH);
      illegal_op <= (state == S_DECODE) && illegal_dec;
      if (state == S_MUL_EX)
        mul_cnt <= mul_done ? '0 : mul_cnt + CNT_W'(1);
    end
  end

  // Next-state and Moore-style strobes; FETCH qualifies IR/PC writes on mem_ready.
  always_comb begin
    next_state    = state;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    pc_source     = 2'd0;
    link          = 1'b0;
    arith_u       = 1'b0;
    byte_control  = 4'b0000;
    alu_opcode    = '0;
`ifdef MC_CTRL_COP0_EN
    coprocessor   = 1'b0;
`endif
    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'd1;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'd3;
        if (is_load || is_store) next_state = S_MEMADR;
        else if (is_rtype)       next_state = S_RTYPE_EX;
        else if (is_imm)         next_state = S_IMM_EX;
        else if (is_mul)         next_state = S_MUL_EX;
        else if (is_branch)      next_state = S_BRANCH;
        else if (is_jump)        next_state = S_JUMP;
        else if (is_cop)         next_state = S_COP_EX;
        else                     next_state = S_FETCH;
      end
      S_MEMADR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'd2;
        next_state = is_load ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_read     = 1'b1;
        i_or_d       = 1'b1;
        byte_control = width_bc;
        if (mem_ready) next_state = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        arith_u    = (opcode == 6'd36) || (opcode == 6'd37);
        next_state = S_FETCH;
      end
      S_MEMWR: begin
        mem_write    = 1'b1;
        i_or_d       = 1'b1;
        byte_control = width_bc;
        if (mem_ready) next_state = S_FETCH;
      end
      S_RTYPE_EX: begin
        alu_src_a  = 1'b1;
        alu_opcode = ALUOP_W'(2);
        next_state = S_ALU_WB;
        if (funct == 6'd8 || funct == 6'd9) begin
          pc_write   = 1'b1;
          pc_source  = 2'd3;
          next_state = S_FETCH;
          if (funct == 6'd9) begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
            link      = 1'b1;
          end
        end
      end
      S_IMM_EX: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'd2;
        next_state = S_ALU_WB;
        case (opcode)
          6'd12:   begin alu_opcode = ALUOP_W'(4); arith_u = 1'b1; end
          6'd13:   begin alu_opcode = ALUOP_W'(5); arith_u = 1'b1; end
          6'd14:   begin alu_opcode = ALUOP_W'(6); arith_u = 1'b1; end
          6'd10:   alu_opcode = ALUOP_W'(7);
          6'd11:   alu_opcode = ALUOP_W'(8);
          6'd15:   alu_opcode = ALUOP_W'(9);
          default: alu_opcode = ALUOP_W'(0);
        endcase
      end
      S_MUL_EX: begin
        alu_opcode = ALUOP_W'(10);
        if (mul_done) next_state = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write  = 1'b1;
        reg_dst    = !is_imm;
        next_state = S_FETCH;
      end
      S_BRANCH: begin
        alu_opcode    = ALUOP_W'(3);
        alu_src_a     = 1'b1;
        pc_write_cond = 1'b1;
        pc_source     = 2'd1;
        next_state    = S_FETCH;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'd2;
        reg_write  = (opcode == 6'd3);
        link       = (opcode == 6'd3);
        next_state = S_FETCH;
      end
`ifdef MC_CTRL_COP0_EN
      S_COP_EX: begin
        coprocessor = 1'b1;
        reg_write   = (cop_rs == 5'd0);
        next_state  = S_FETCH;
      end
`endif
      default: next_state = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// tb_mc_control_unit: randomized self-checking bench for mc_control_unit.
// A per-instruction model expands each instruction into its expected
// cycle-by-cycle strobe trace; the DUT is stepped in lockstep and compared.
module tb_mc_control_unit;
  localparam int MULC = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, funct;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a, link, arith_u;
  logic [1:0] alu_src_b, pc_source;
  logic [3:0] byte_control;
  logic [4:0] alu_opcode;
  logic       busy, illegal_op;

  typedef struct packed {
    logic       rdy;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, pc_source;
    logic       link, arith_u;
    logic [3:0] byte_control;
    logic [4:0] alu_opcode;
    logic       busy, illegal_op;
  } cyc_t;

  cyc_t exp_q[$];
  cyc_t obs_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic pend_ill = 1'b0;

  mc_control_unit #(.ALUOP_W(5), .MUL_CYCLES(MULC), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
    .link(link), .arith_u(arith_u), .byte_control(byte_control),
    .alu_opcode(alu_opcode), .busy(busy), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  function automatic cyc_t sample(input logic rdy);
    cyc_t o;
    o = '0;
    o.rdy = rdy; o.pc_write = pc_write; o.pc_write_cond = pc_write_cond;
    o.i_or_d = i_or_d; o.mem_read = mem_read; o.mem_write = mem_write;
    o.ir_write = ir_write; o.reg_dst = reg_dst; o.mem_to_reg = mem_to_reg;
    o.reg_write = reg_write; o.alu_src_a = alu_src_a; o.alu_src_b = alu_src_b;
    o.pc_source = pc_source; o.link = link; o.arith_u = arith_u;
    o.byte_control = byte_control; o.alu_opcode = alu_opcode;
    o.busy = busy; o.illegal_op = illegal_op;
    return o;
  endfunction

  function automatic cyc_t work(input logic rdy_rand);
    cyc_t r;
    r = '0;
    r.busy = 1'b1;
    r.rdy = rdy_rand;
    return r;
  endfunction

  // Expected trace of one instruction: fw FETCH stalls, mw memory stalls.
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw);
    cyc_t r;
    logic [3:0] bw;
    bit ld, st, im, br;
    exp_q.delete();
    ld = (op == 35 || op == 32 || op == 33 || op == 36 || op == 37);
    st = (op == 43 || op == 40 || op == 41);
    im = (op >= 8 && op <= 15);
    br = (op == 1 || (op >= 4 && op <= 7));
    bw = (op == 35 || op == 43) ? 4'b1111 :
         (op == 33 || op == 37 || op == 41) ? 4'b0011 : 4'b0001;
    for (int i = 0; i <= fw; i++) begin
      r = '0;
      r.mem_read = 1'b1; r.alu_src_b = 2'd1;
      r.illegal_op = (i == 0) && pend_ill;
      r.rdy = (i == fw);
      r.ir_write = r.rdy; r.pc_write = r.rdy;
      exp_q.push_back(r);
    end
    pend_ill = 1'b0;
    r = work(1'($urandom_range(0, 1))); r.alu_src_b = 2'd3; exp_q.push_back(r);
    if (ld || st) begin
      r = work(1'($urandom_range(0, 1))); r.alu_src_a = 1'b1; r.alu_src_b = 2'd2;
      exp_q.push_back(r);
      for (int i = 0; i <= mw; i++) begin
        r = work(i == mw); r.i_or_d = 1'b1; r.byte_control = bw;
        if (ld) r.mem_read = 1'b1; else r.mem_write = 1'b1;
        exp_q.push_back(r);
      end
      if (ld) begin
        r = work(1'($urandom_range(0, 1))); r.reg_write = 1'b1; r.mem_to_reg = 1'b1;
        r.arith_u = (op == 36 || op == 37);
        exp_q.push_back(r);
      end
    end else if (op == 0 || op == 28 || im) begin
      if (op == 28) begin
        for (int i = 0; i < MULC; i++) begin
          r = work(1'($urandom_range(0, 1))); r.alu_opcode = 5'd10; exp_q.push_back(r);
        end
      end else begin
        r = work(1'($urandom_range(0, 1))); r.alu_src_a = 1'b1;
        if (op == 0) r.alu_opcode = 5'd2;
        else begin
          r.alu_src_b = 2'd2;
          r.alu_opcode = (op == 12) ? 5'd4 : (op == 13) ? 5'd5 : (op == 14) ? 5'd6 :
                         (op == 10) ? 5'd7 : (op == 11) ? 5'd8 : (op == 15) ? 5'd9 : 5'd0;
          r.arith_u = (op >= 12 && op <= 14);
        end
        if (op == 0 && (fn == 8 || fn == 9)) begin
          r.pc_write = 1'b1; r.pc_source = 2'd3;
          if (fn == 9) begin r.reg_write = 1'b1; r.reg_dst = 1'b1; r.link = 1'b1; end
        end
        exp_q.push_back(r);
      end
      if (!(op == 0 && (fn == 8 || fn == 9))) begin
        r = work(1'($urandom_range(0, 1))); r.reg_write = 1'b1; r.reg_dst = !im;
        exp_q.push_back(r);
      end
    end else if (br) begin
      r = work(1'($urandom_range(0, 1))); r.alu_opcode = 5'd3; r.alu_src_a = 1'b1;
      r.pc_write_cond = 1'b1; r.pc_source = 2'd1; exp_q.push_back(r);
    end else if (op == 2 || op == 3) begin
      r = work(1'($urandom_range(0, 1))); r.pc_write = 1'b1; r.pc_source = 2'd2;
      r.reg_write = (op == 3); r.link = (op == 3); exp_q.push_back(r);
    end else begin
      pend_ill = 1'b1;
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] fn);
    obs_q.delete();
    foreach (exp_q[i]) begin
      @(negedge clk);
      opcode = op; funct = fn; mem_ready = exp_q[i].rdy;
      #1;
      obs_q.push_back(sample(exp_q[i].rdy));
    end
  endtask

  task automatic test_reset();
    cyc_t e;
    rst = 1'b1; mem_ready = 1'b0; opcode = 6'd0; funct = 6'd0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    e = '0; e.mem_read = 1'b1; e.alu_src_b = 2'd1;
    n_tests++;
    if (sample(1'b0) !== e) begin
      n_fail++; $display("FAIL reset_state got=%h exp=%h", sample(1'b0), e);
    end
    rst = 1'b0;
  endtask

  task automatic test_lw();
    int wr;
    build(6'd35, 6'd0, 0, 0); drive(6'd35, 6'd0);
    wr = 0;
    foreach (exp_q[i]) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL lw cyc%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
      if (obs_q[i].reg_write) wr = wr + 1;
    end
    n_tests++;
    if (wr !== 1 || obs_q[4].mem_to_reg !== 1'b1) begin
      n_fail++; $display("FAIL lw_wb_once got=%0d/%b exp=1/1", wr, obs_q[4].mem_to_reg);
    end
  endtask

  task automatic test_sb_wait();
    int mw;
    build(6'd40, 6'd0, 0, 3); drive(6'd40, 6'd0);
    mw = 0;
    foreach (exp_q[i]) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL sb cyc%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
      if (obs_q[i].mem_write && obs_q[i].byte_control == 4'b0001) mw = mw + 1;
    end
    n_tests++;
    if (mw !== 4) begin n_fail++; $display("FAIL sb_write_cycles got=%0d exp=4", mw); end
  endtask

  task automatic test_mul();
    int mc;
    build(6'd28, 6'd0, 0, 0); drive(6'd28, 6'd0);
    mc = 0;
    foreach (exp_q[i]) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL mul cyc%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
      if (obs_q[i].alu_opcode == 5'd10) mc = mc + 1;
    end
    n_tests++;
    if (mc !== MULC || obs_q[5].reg_write !== 1'b1 || obs_q[5].reg_dst !== 1'b1) begin
      n_fail++; $display("FAIL mul_hold got=%0d exp=%0d", mc, MULC);
    end
  endtask

  task automatic test_jalr();
    build(6'd0, 6'd9, 0, 0); drive(6'd0, 6'd9);
    foreach (exp_q[i]) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL jalr cyc%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_illegal();
    build(6'd63, 6'd0, 0, 0); drive(6'd63, 6'd0);
    foreach (exp_q[i]) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL ill cyc%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
    build(6'd2, 6'd0, 1, 0); drive(6'd2, 6'd0);
    foreach (exp_q[i]) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL ill_next cyc%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [5:0] pool[28] = '{35, 32, 33, 36, 37, 43, 40, 41, 0, 0, 0, 8, 9, 10, 11, 12,
                             13, 14, 15, 28, 4, 5, 6, 7, 1, 2, 3, 16};
    logic [5:0] fpool[4] = '{8, 9, 32, 42};
    logic [5:0] op, fn;
    for (int k = 0; k < 60; k++) begin
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63)) : pool[$urandom_range(0, 27)];
      fn = fpool[$urandom_range(0, 3)];
      build(op, fn, $urandom_range(0, 2), $urandom_range(0, 3));
      drive(op, fn);
      foreach (exp_q[i]) begin
        n_tests++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL rand op%0d fn%0d cyc%0d got=%h exp=%h", op, fn, i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_memrd();
    logic rdy_seq[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    foreach (rdy_seq[i]) begin
      @(negedge clk); opcode = 6'd35; funct = 6'd0; mem_ready = rdy_seq[i];
    end
    #1;
    n_tests++;
    if (mem_read !== 1'b1 || i_or_d !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL memrd_wait got=%b%b%b exp=111", mem_read, i_or_d, busy);
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); #1;
    n_tests++;
    if (i_or_d !== 1'b0 || mem_read !== 1'b1) begin
      n_fail++; $display("FAIL rst_in_reset got=%b%b exp=01", i_or_d, mem_read);
    end
    @(negedge clk); rst = 1'b0; mem_ready = 1'b0; #1;
    n_tests++;
    if ({mem_read, i_or_d, busy, reg_write, illegal_op, alu_src_b} !== {5'b10000, 2'd1}) begin
      n_fail++;
      $display("FAIL rst_mid_memrd got=%b%b%b%b%b%0d exp=100001", mem_read, i_or_d, busy,
               reg_write, illegal_op, alu_src_b);
    end
    pend_ill = 1'b0;
    build(6'd43, 6'd0, 0, 1); drive(6'd43, 6'd0);
    foreach (exp_q[i]) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL post_rst cyc%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sb_wait();
    test_mul();
    test_jalr();
    test_illegal();
    test_random();
    test_reset_mid_memrd();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
- Multi-cycle successor to the single-cycle MIPS control decoder.
- FSM sequences each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK over a shared memory and ALU.
- Stalls on a memory ready handshake and on a parametrised multi-cycle multiplier.
- Sits between the instruction register (opcode/funct) and the multi-cycle datapath muxes, register file and memory port.

Parameters:
- ALUOP_W, 5, width of alu_opcode; ALU class codes zero-extended into it.
- MUL_CYCLES, 3, EXECUTE cycles held for mul (opcode 28); legal range 1..15.
- CNT_W, 4, width of the mul hold counter; must satisfy 2^CNT_W > MUL_CYCLES.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- opcode  in  6  IR[31:26], valid from DECODE onward
- funct  in  6  IR[5:0]
- mem_ready  in  1  memory completes the current access this cycle
- pc_write  out  1  unconditional PC update
- pc_write_cond  out  1  PC update if branch condition is true
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  load IR
- reg_dst  out  1  1 = rd, 0 = rt
- mem_to_reg  out  1  writeback from MDR
- reg_write  out  1  register file write enable
- alu_src_a  out  1  0 = PC, 1 = A
- alu_src_b  out  2  0 = B, 1 = constant 4, 2 = sign-extended immediate, 3 = immediate<<2
- pc_source  out  2  0 = ALU, 1 = ALUOut, 2 = jump target, 3 = A (jr)
- link  out  1  write PC+4 to $31 (jal) or rd (jalr)
- arith_u  out  1  zero-extend immediate / load data
- byte_control  out  4  1111 word, 0011 half, 0001 byte, 0000 none
- alu_opcode  out  ALUOP_W  ALU class code
- busy  out  1  high in every state except FETCH
- illegal_op  out  1  one-cycle pulse on an unsupported opcode

Behaviour:
- Reset: state = FETCH, mul counter = 0. Registered outputs reset to 0: busy, illegal_op. All other outputs decode from state and are 0 in any state that does not assert them.
- Outputs are Moore-decoded from state, with opcode/funct qualifiers in DECODE and later states.
- FETCH:
  - mem_read = 1, i_or_d = 0, alu_src_a = 0, alu_src_b = 1, alu_opcode = 0.
  - On mem_ready: ir_write = 1, pc_write = 1, go to DECODE.
  - Otherwise hold FETCH with no IR or PC write.
- DECODE: alu_src_a = 0, alu_src_b = 3 (branch target precompute). Next state by opcode:
  - 35/32/33/36/37/43/40/41 → MEMADR
  - 0 → RTYPE_EX
  - 8/9/10/11/12/13/14/15 → IMM_EX
  - 28 → MUL_EX
  - 4/5/6/7/1 → BRANCH
  - 2/3 → JUMP
  - other → FETCH with illegal_op = 1 for 1 cycle; no reg/mem/PC write.
- MEMADR: alu_src_a = 1, alu_src_b = 2, alu_opcode = 0. Go to MEMRD (loads) or MEMWR (stores).
- MEMRD: mem_read = 1, i_or_d = 1, byte_control per width. Hold until mem_ready, then go to MEMWB.
- MEMWB: reg_write = 1, mem_to_reg = 1, reg_dst = 0, arith_u = 1 for lbu/lhu. Go to FETCH.
- MEMWR: mem_write = 1, i_or_d = 1, byte_control per width. Hold until mem_ready, then go to FETCH. mem_write stays high while waiting.
- RTYPE_EX: alu_src_a = 1, alu_src_b = 0, alu_opcode = 2.
  - funct 8 (jr): pc_write = 1, pc_source = 3, go to FETCH (3 cycles total).
  - funct 9 (jalr): pc_write = 1, pc_source = 3, reg_write = 1, reg_dst = 1, link = 1, go to FETCH.
  - else: go to ALU_WB.
- IMM_EX: alu_src_a = 1, alu_src_b = 2. alu_opcode: addi/addiu 0, andi 4, ori 5, xori 6, slti 7, sltiu 8, lui 9. arith_u = 1 for andi/ori/xori. Go to ALU_WB.
- MUL_EX: alu_opcode = 10. Counter increments from 0; leave when counter == MUL_CYCLES-1, then clear it and go to ALU_WB. MUL_CYCLES = 1 gives a single cycle.
- ALU_WB: reg_write = 1, reg_dst = 1 for RTYPE/MUL, 0 for IMM. Go to FETCH.
- BRANCH: alu_opcode = 3, alu_src_a = 1, alu_src_b = 0, pc_write_cond = 1, pc_source = 1. Go to FETCH.
- JUMP: pc_write = 1, pc_source = 2. jal also sets reg_write = 1 and link = 1. Go to FETCH.
- Cycle counts with mem_ready tied high:
  - lw 5, sw 4, R-type 4, imm 4, mul 3+MUL_CYCLES, branch 3, j/jr 3.
- Any rst assertion mid-instruction: FETCH on the next edge and all strobes drop. A partially started store is not retried.

Optional Feature:
- MC_CTRL_COP0_EN
- Defined:
  - opcode 16 goes DECODE → COP_EX. COP_EX drives coprocessor = 1 (extra 1-bit output port), reg_write = rs[4:0]==0 (mfc0), reg_dst = 0, then FETCH.
  - The rs field is taken as extra input cop_rs[4:0].
- Undefined:
  - Ports coprocessor/cop_rs are absent.
  - opcode 16 is illegal (illegal_op pulse, back to FETCH).

Test Plan:
- rst high 2 cycles mid-MEMRD → next cycle FETCH, mem_read = 1, busy = 0, reg_write = 0, illegal_op = 0.
- lw (opcode 35), mem_ready = 1 → states FETCH, DECODE, MEMADR, MEMRD, MEMWB. reg_write = 1 and mem_to_reg = 1 only in cycle 5; byte_control = 1111.
- sb (opcode 40), mem_ready low 3 cycles in MEMWR → mem_write = 1 for 4 cycles, byte_control = 0001, return to FETCH after ready.
- mul (opcode 28), MUL_CYCLES = 3 → alu_opcode = 10 for exactly 3 MUL_EX cycles. reg_write = 1, reg_dst = 1 on cycle 6.
- jalr (opcode 0, funct 9) → in cycle 3: pc_write = 1, pc_source = 3, link = 1, reg_write = 1, reg_dst = 1.
- opcode 63 → illegal_op = 1 for exactly one cycle after DECODE; no pc_write or reg_write; next fetch proceeds normally.
